// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core parameters and width helpers
package ooo_pkg;

  // Reorder buffer depth; the tag carries one extra bit beyond the entry index.
  localparam int ROB_ELEMENTS = 15;
  localparam int TAG_WIDTH    = $clog2(ROB_ELEMENTS + 1) + 1;

  // Completions the ROB can absorb per cycle.
  localparam int PUSH_WIDTH   = 3;

  // Width of a counter able to hold 0..pw.
  function automatic int cnt_width(input int pw);
    return $clog2(pw) + 1;
  endfunction

endpackage

// File: rtl/cmplt_rr_pick.sv
// rtl/cmplt_rr_pick.sv - combinational round-robin picker of up to PUSH_WIDTH requesters
module cmplt_rr_pick
  import ooo_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int PUSH_WIDTH = ooo_pkg::PUSH_WIDTH,
  parameter int PTR_W      = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1,
  parameter int CNT_W      = cnt_width(PUSH_WIDTH)
) (
  input  logic [NUM_UNITS-1:0]        req,
  input  logic [PTR_W-1:0]            start,
  output logic [NUM_UNITS-1:0]        grant,
  output logic [PUSH_WIDTH*PTR_W-1:0] idx_list,
  output logic [CNT_W-1:0]            grant_cnt,
  output logic [PTR_W-1:0]            next_ptr
);

  int cnt_c;
  int unit_c;

  // Scan from start with modulo wrap, granting the first PUSH_WIDTH requesters in order.
  always_comb begin
    grant    = '0;
    idx_list = '0;
    next_ptr = start;
    cnt_c    = 0;
    unit_c   = 0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      unit_c = (int'(start) + j) % NUM_UNITS;
      if (req[unit_c] && (cnt_c < PUSH_WIDTH)) begin
        grant[unit_c]                    = 1'b1;
        idx_list[cnt_c*PTR_W +: PTR_W]   = PTR_W'(unit_c);
        next_ptr                         = PTR_W'((unit_c + 1) % NUM_UNITS);
        cnt_c                            = cnt_c + 1;
      end
    end
    grant_cnt = CNT_W'(cnt_c);
  end

endmodule

// File: rtl/cmplt_arb.sv
// rtl/cmplt_arb.sv - completion arbiter feeding execution-unit tags into the ROB completion port
module cmplt_arb
  import ooo_pkg::*;
#(
  parameter int TAG_WIDTH  = ooo_pkg::TAG_WIDTH,
  parameter int NUM_UNITS  = 4,
  parameter int PUSH_WIDTH = ooo_pkg::PUSH_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]    unit_tag,
  input  logic [NUM_UNITS-1:0]              unit_valid,
  output logic [NUM_UNITS-1:0]              unit_ready,
  output logic [PUSH_WIDTH*TAG_WIDTH-1:0]   completed,
  output logic [cnt_width(PUSH_WIDTH)-1:0]  cmplt_valid_ct
);

  localparam int PTR_W = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = cnt_width(PUSH_WIDTH);

  logic [NUM_UNITS-1:0]        held_q, held_d;
  logic [TAG_WIDTH-1:0]        hold_tag_q [NUM_UNITS];
  logic [TAG_WIDTH-1:0]        hold_tag_d [NUM_UNITS];
  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NUM_UNITS-1:0]        grant;
  logic [PUSH_WIDTH*PTR_W-1:0] pick_idx;
  logic [CNT_W-1:0]            grant_cnt;
  logic [PTR_W-1:0]            pick_next;

  cmplt_rr_pick #(
    .NUM_UNITS  (NUM_UNITS),
    .PUSH_WIDTH (PUSH_WIDTH),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_pick (
    .req       (held_q),
    .start     (rr_ptr_q),
    .grant     (grant),
    .idx_list  (pick_idx),
    .grant_cnt (grant_cnt),
    .next_ptr  (pick_next)
  );

  // A unit may hand over a new tag when its slot is empty or is being drained this cycle.
  assign unit_ready = {NUM_UNITS{~flush}} & (~held_q | grant);

  // Route granted tags into the low slots in scan order; flush suppresses all output.
  always_comb begin
    completed      = '0;
    cmplt_valid_ct = flush ? '0 : grant_cnt;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      if (!flush && (k < int'(grant_cnt))) begin
        completed[k*TAG_WIDTH +: TAG_WIDTH] = hold_tag_q[pick_idx[k*PTR_W +: PTR_W]];
      end
    end
  end

  // Next holding state: flush clears, accept beats drain, drain frees the slot.
  always_comb begin
    held_d     = held_q;
    hold_tag_d = hold_tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      held_d = '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (unit_valid[i] && unit_ready[i]) begin
          held_d[i]     = 1'b1;
          hold_tag_d[i] = unit_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end else if (grant[i]) begin
          held_d[i] = 1'b0;
        end
      end
      if (grant_cnt != '0) begin
        rr_ptr_d = pick_next;
      end
    end
  end

  // Occupancy and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag payload registers; contents are only observed while the matching held bit is set.
  always_ff @(posedge clk) begin
    hold_tag_q <= hold_tag_d;
  end

endmodule
